// File: rtl/msk_framer_pkg.sv
// Shared types and helpers for the MSK receive UART framer.
// Latency: n/a. Backpressure: n/a.
// crc8_40 backs the MSK_FRAMER_CRC8_EN checksum option.
package msk_framer_pkg;

    localparam int FRAME_BYTES = 8;

    localparam logic [7:0] DEF_HDR0 = 8'hEB;
    localparam logic [7:0] DEF_HDR1 = 8'h90;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    // CRC-8, poly 0x07, init 0, no reflection, no final XOR; MSB of d goes in first.
    function automatic logic [7:0] crc8_40(input logic [39:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic logic [7:0] frame_byte(
        input logic [2:0]  idx,
        input logic [7:0]  hdr0,
        input logic [7:0]  hdr1,
        input logic [7:0]  seq,
        input logic [31:0] w,
        input logic [7:0]  chk
    );
        case (idx)
            3'd0:    return hdr0;
            3'd1:    return hdr1;
            3'd2:    return seq;
            3'd3:    return w[31:24];
            3'd4:    return w[23:16];
            3'd5:    return w[15:8];
            3'd6:    return w[7:0];
            default: return chk;
        endcase
    endfunction

endpackage

// File: rtl/msk_word_fifo.sv
// Single-clock word FIFO with occupancy count; read data is the head entry, combinational.
// Latency: a push is visible on empty/level one cycle later.
// Backpressure: push while full is accepted only if pop is asserted in the same cycle.
module msk_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rd_en   = pop && !empty;
    assign wr_en   = push && (!full || rd_en);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                level <= level + 1'b1;
            end else if (rd_en && !wr_en) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/msk_rx_uart_framer.sv
// Wraps demodulated 32-bit words into 8-byte UART frames (hdr0 hdr1 seq d3..d0 chk).
// Latency: valid rises 3 cycles after a strobe into an idle framer; 8 cycles per frame at full rate.
// Backpressure: byte_out held under ready=0; words arriving with the FIFO full are dropped and counted.
// Build option MSK_FRAMER_CRC8_EN swaps the sum checksum for CRC-8.
module msk_rx_uart_framer
    import msk_framer_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] HDR0       = DEF_HDR0,
    parameter logic [7:0] HDR1       = DEF_HDR1
) (
    input  logic                        logic_clk_in,
    input  logic                        logic_rst_in,
    input  logic [31:0]                 word_in,
    input  logic                        word_in_en,
    output logic [7:0]                  byte_out,
    output logic                        byte_out_valid,
    input  logic                        byte_out_ready,
    output logic                        frame_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 overflow_cnt,
    output logic                        overflow_pulse
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

    state_t      state;
    logic [31:0] word_r;
    logic [7:0]  seq;
    logic [7:0]  chk_r;
    logic [7:0]  chk_calc;
    logic [2:0]  idx;

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic        word_drop;
    logic [31:0] fifo_rd_word;

    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign fifo_push = word_in_en && (!fifo_full || fifo_pop);
    assign word_drop = word_in_en && !fifo_push;

    msk_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_word_fifo (
        .clk     (logic_clk_in),
        .rst     (logic_rst_in),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (word_in),
        .rd_data (fifo_rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        chk_calc = 8'h00;
`ifdef MSK_FRAMER_CRC8_EN
        chk_calc = crc8_40({seq, word_r});
`else
        chk_calc = seq + word_r[31:24] + word_r[23:16] + word_r[15:8] + word_r[7:0];
`endif
    end

    always_ff @(posedge logic_clk_in) begin
        if (logic_rst_in) begin
            state          <= IDLE;
            word_r         <= '0;
            seq            <= '0;
            chk_r          <= '0;
            idx            <= '0;
            byte_out       <= '0;
            byte_out_valid <= 1'b0;
            frame_busy     <= 1'b0;
            overflow_cnt   <= '0;
            overflow_pulse <= 1'b0;
        end else begin
            overflow_pulse <= word_drop;
            if (word_drop && overflow_cnt != 16'hFFFF) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        word_r     <= fifo_rd_word;
                        frame_busy <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    chk_r          <= chk_calc;
                    idx            <= '0;
                    byte_out       <= HDR0;
                    byte_out_valid <= 1'b1;
                    state          <= SEND;
                end
                SEND: begin
                    if (byte_out_valid && byte_out_ready) begin
                        if (idx == LAST_IDX) begin
                            byte_out_valid <= 1'b0;
                            frame_busy     <= 1'b0;
                            seq            <= seq + 8'd1;
                            state          <= IDLE;
                        end else begin
                            idx      <= idx + 3'd1;
                            byte_out <= frame_byte(idx + 3'd1, HDR0, HDR1, seq, word_r, chk_r);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msk_rx_uart_framer.sv
// Randomized bench for msk_rx_uart_framer with a byte-queue frame model.
module tb_msk_rx_uart_framer;

    logic        logic_clk_in = 1'b0;
    logic        logic_rst_in = 1'b1;
    logic [31:0] word_in      = '0;
    logic        word_in_en   = 1'b0;
    logic        byte_out_ready = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_out_valid;
    logic        frame_busy;
    logic [2:0]  fifo_level;
    logic [15:0] overflow_cnt;
    logic        overflow_pulse;

    msk_rx_uart_framer dut (
        .logic_clk_in   (logic_clk_in),
        .logic_rst_in   (logic_rst_in),
        .word_in        (word_in),
        .word_in_en     (word_in_en),
        .byte_out       (byte_out),
        .byte_out_valid (byte_out_valid),
        .byte_out_ready (byte_out_ready),
        .frame_busy     (frame_busy),
        .fifo_level     (fifo_level),
        .overflow_cnt   (overflow_cnt),
        .overflow_pulse (overflow_pulse)
    );

    always #5 logic_clk_in = ~logic_clk_in;

    int         tests = 0;
    int         errs  = 0;
    int         ovf_seen = 0;
    logic [7:0] exp_q [$];
    logic [7:0] m_seq = 8'h00;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte  = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference checksum, byte-serial form of the frame rules.
    function automatic logic [7:0] ref_chk(input logic [7:0] s, input logic [31:0] w);
        logic [7:0] b [5];
        logic [7:0] c;
        int         sum;
        b[0] = s; b[1] = w[31:24]; b[2] = w[23:16]; b[3] = w[15:8]; b[4] = w[7:0];
        c   = 8'h00;
        sum = 0;
        for (int i = 0; i < 5; i++) begin
            sum += int'(b[i]);
            c = c ^ b[i];
            for (int k = 0; k < 8; k++) begin
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
            end
        end
`ifdef MSK_FRAMER_CRC8_EN
        return c;
`else
        return 8'(sum % 256);
`endif
    endfunction

    task automatic add_frame(input logic [31:0] w);
        exp_q.push_back(8'hEB);
        exp_q.push_back(8'h90);
        exp_q.push_back(m_seq);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(ref_chk(m_seq, w));
        m_seq = m_seq + 8'd1;
    endtask

    task automatic tick();
        @(posedge logic_clk_in);
        #1;
    endtask

    task automatic do_reset();
        logic_rst_in = 1'b1;
        word_in_en   = 1'b0;
        exp_q.delete();
        m_seq = 8'h00;
        tick();
        tick();
        logic_rst_in = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] w, input bit expect_accept);
        word_in    = w;
        word_in_en = 1'b1;
        if (expect_accept) add_frame(w);
        tick();
        word_in_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || frame_busy) && n < budget) begin
            tick();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_busy", frame_busy, 0);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!byte_out_valid && n < budget) begin
            tick();
            n++;
        end
        check("wait_valid", byte_out_valid, 1);
    endtask

    always @(negedge logic_clk_in) begin
        if (logic_rst_in) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", byte_out_valid, 1);
                check("hold_byte", byte_out, prev_byte);
            end
            if (overflow_pulse) ovf_seen++;
            if (byte_out_valid && byte_out_ready) begin
                if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
                else check("frame_byte", byte_out, exp_q.pop_front());
            end
            prev_stall = byte_out_valid && !byte_out_ready;
            prev_byte  = byte_out;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;

        // Reset state
        do_reset();
        check("rst_byte", byte_out, 0);
        check("rst_valid", byte_out_valid, 0);
        check("rst_busy", frame_busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf_cnt", overflow_cnt, 0);
        check("rst_ovf_pulse", overflow_pulse, 0);

        // Single frame, latency and back-to-back byte timing
        byte_out_ready = 1'b1;
        strobe(32'h12345678, 1'b0);
        exp_q.push_back(8'hEB); exp_q.push_back(8'h90); exp_q.push_back(8'h00);
        exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56);
        exp_q.push_back(8'h78);
`ifdef MSK_FRAMER_CRC8_EN
        exp_q.push_back(ref_chk(8'h00, 32'h12345678));
`else
        exp_q.push_back(8'h14);
`endif
        m_seq = 8'h01;
        tick();
        check("lat_valid_early", byte_out_valid, 0);
        tick();
        check("lat_valid_rise", byte_out_valid, 1);
        check("lat_first_byte", byte_out, 8'hEB);
        for (int i = 0; i < 8; i++) tick();
        check("s1_valid_low", byte_out_valid, 0);
        check("s1_all_bytes", exp_q.size(), 0);
        check("s1_busy_low", frame_busy, 0);

        // Backpressure while byte index 3 is presented
        byte_out_ready = 1'b0;
        strobe(32'h12345678, 1'b1);
        wait_valid(10);
        byte_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        byte_out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_byte", byte_out, 8'h12);
            check("bp_valid", byte_out_valid, 1);
            tick();
        end
        byte_out_ready = 1'b1;
        drain(40);

        // Overflow: sixth word dropped
        do_reset();
        ovf_seen = 0;
        byte_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            strobe($urandom, i < 5);
            for (int k = 0; k < 4; k++) tick();
        end
        check("ovf_level", fifo_level, 4);
        check("ovf_busy", frame_busy, 1);
        check("ovf_cnt", overflow_cnt, 1);
        check("ovf_pulses", ovf_seen, 1);
        byte_out_ready = 1'b1;
        drain(200);
        check("ovf_level_after", fifo_level, 0);

        // Sequence wrap over 257 frames at full rate
        do_reset();
        byte_out_ready = 1'b1;
        for (int n = 0; n < 257; n++) begin
            strobe($urandom, 1'b1);
            for (int k = 0; k < 11; k++) tick();
        end
        drain(100);
        check("wrap_next_seq", m_seq, 8'h01);
        check("wrap_no_drop", overflow_cnt, 0);

        // Random words with random ready
        for (int n = 0; n < 40; n++) begin
            gap = $urandom_range(30, 50);
            for (int c = 0; c < gap; c++) begin
                byte_out_ready = ($urandom_range(0, 3) != 0);
                if (c == 0) strobe($urandom, 1'b1);
                else tick();
            end
        end
        byte_out_ready = 1'b1;
        drain(200);
        check("rand_no_drop", overflow_cnt, 0);

        // Reset in the middle of a frame with words queued
        byte_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            strobe($urandom, 1'b1);
            tick();
        end
        wait_valid(10);
        byte_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        logic_rst_in   = 1'b1;
        byte_out_ready = 1'b0;
        exp_q.delete();
        m_seq = 8'h00;
        tick();
        check("mid_rst_valid", byte_out_valid, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_busy", frame_busy, 0);
        logic_rst_in   = 1'b0;
        byte_out_ready = 1'b1;
        tick();
        strobe(32'h00000000, 1'b1);
        drain(40);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule

// File: doc/msk_rx_uart_framer.md
Name: msk_rx_uart_framer

Overview:
- Downstream consumer of the MSK demodulator's 32-bit word output: `data_msk_out` plus its one-cycle `data_msk_out_en` pulse, one pulse per 1.5 ms hop.
- Buffers received words in a small FIFO and wraps each word in an 8-byte frame: two header bytes, sequence number, 4 data bytes MSB first, checksum.
- Streams frames one byte at a time to the UART transmitter over a valid/ready handshake, replacing the ad-hoc 64-bit UART packing path.
- Runs entirely on the 200 MHz logic clock.

Parameters:
- FIFO_DEPTH, 4, word FIFO depth; power of two, minimum 2.
- HDR0, 8'hEB, first frame header byte.
- HDR1, 8'h90, second frame header byte.

Ports:
- logic_clk_in  input  1  200 MHz logic clock.
- logic_rst_in  input  1  synchronous reset, active-high.
- word_in  input  32  demodulated word (connects to data_msk_out).
- word_in_en  input  1  one-cycle word strobe (connects to data_msk_out_en).
- byte_out  output  8  frame byte to UART TX.
- byte_out_valid  output  1  byte_out holds a valid byte.
- byte_out_ready  input  1  UART TX accepts the byte this cycle.
- frame_busy  output  1  a frame is being emitted (state is not IDLE).
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of words held in the FIFO.
- overflow_cnt  output  16  count of dropped words; saturates at 16'hFFFF.
- overflow_pulse  output  1  one-cycle pulse for each dropped word.

Behaviour:
Reset:
- Every register is cleared on a clock edge where logic_rst_in=1. After reset: byte_out=0, byte_out_valid=0, frame_busy=0, fifo_level=0, overflow_cnt=0, overflow_pulse=0, sequence counter=0, state=IDLE.
- Reset mid-frame discards the partial frame and all FIFO contents. byte_out_valid is low from the first edge at which reset is sampled.

FIFO:
- Write occurs when word_in_en=1 and either the FIFO is not full, or a pop happens in the same cycle.
- Otherwise the word is dropped: overflow_pulse=1 on the next cycle, and overflow_cnt increments unless it is already saturated.
- fifo_level updates one cycle after a push or pop. A simultaneous push and pop leaves it unchanged.

FSM (IDLE, LOAD, SEND):
- IDLE: if the FIFO is non-empty, pop and go to LOAD.
- LOAD (one cycle):
  - latch the popped word;
  - chk = (seq + w[31:24] + w[23:16] + w[15:8] + w[7:0]) mod 256;
  - set byte index = 0;
  - go to SEND.
- SEND: byte_out_valid=1 and byte_out = frame[index]. Frame order is HDR0, HDR1, seq, w[31:24], w[23:16], w[15:8], w[7:0], chk.
  - Byte transfer occurs when byte_out_valid and byte_out_ready are both 1 in the same cycle; index then increments.
  - While valid=1 and ready=0, byte_out is held stable and valid stays high.
  - On transfer of index 7: seq increments (255 wraps to 0) and the FSM returns to IDLE.
  - byte_out_valid is registered and goes low in the cycle after the last transfer.
- There is no bubble requirement between frames. An IDLE→LOAD→SEND gap of 2 cycles is fixed.

Latency:
- With the FIFO empty and the FSM in IDLE, byte_out_valid rises 3 cycles after the word_in_en edge.
- With byte_out_ready held at 1, one byte transfers per cycle, so a frame takes 8 cycles.
- ready may be asserted before valid; ready without valid has no effect.

Optional Feature:
- Macro: MSK_FRAMER_CRC8_EN.
- Defined: chk is CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR) over seq and the 4 data bytes, MSB first.
  - Computed in LOAD as a combinational 40-bit unrolled function.
  - Latency is unchanged.
- Undefined: chk is the mod-256 sum described above.

Decomposition:
- Package msk_framer_pkg holds:
  - frame length constant FRAME_BYTES=8;
  - state enum {IDLE, LOAD, SEND};
  - default header constants;
  - the CRC-8 function.
- One natural sub-module: msk_word_fifo.
  - Synchronous, single clock, DEPTH/WIDTH parameters.
  - Outputs: full, empty, level.
  - Same-cycle push-when-full is allowed if pop is also asserted.

Test Plan:
1. Single frame, default build: reset, ready=1, word 32'h12345678 → bytes EB 90 00 12 34 56 78 14 on 8 consecutive cycles; byte_out_valid first high 3 cycles after the strobe; frame_busy low afterwards.
2. Backpressure: ready=0 for 10 cycles while index=3 (byte 12) is presented → byte_out stays 8'h12 and valid stays 1; the remaining bytes then follow correctly.
3. Overflow: ready=0; 6 words strobed 5 cycles apart → word1 is in the framer, fifo_level=4, word6 dropped, overflow_pulse seen once, overflow_cnt=1. Release ready → 5 frames with seq 00..04 and data in order.
4. Sequence wrap: 257 words with ready=1 → frame 256 has seq FF, frame 257 has seq 00; checksum correct for each.
5. Reset mid-frame: assert reset after byte index 3 transfers, with 2 words queued → next cycle valid=0, fifo_level=0. A new word 32'h00000000 produces EB 90 00 00 00 00 00 00.
6. MSK_FRAMER_CRC8_EN defined: word 32'h12345678, seq 0 → chk equals the reference CRC-8 of {00,12,34,56,78} computed by the bench model; all other bytes identical to scenario 1.
